// File: rtl/peak_window_ctrl.sv
// Windowed peak detector over CMOS frames: tracks the max href-qualified sample per window.
// Optional run_max decay on frame boundaries is enabled by defining PEAK_DECAY_EN.
module peak_window_ctrl #(
    parameter int unsigned WIN_FRAMES = 4,
    parameter int unsigned SETTLE_CYC = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cmos_vsync,
    input  logic       cmos_frame_href,
    input  logic [7:0] indata,
    output logic [7:0] peak_data,
    output logic       peak_valid,
    input  logic       peak_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        SETTLE,
        TRACK,
        REPORT
    } state_t;

    localparam logic [7:0]  WIN_LAST    = WIN_FRAMES[7:0];
    localparam logic [15:0] SETTLE_LAST = SETTLE_CYC[15:0];

    state_t      state_q, state_d;
    logic        vs_q;
    logic [7:0]  run_max_q, run_max_d;
    logic [7:0]  frame_q, frame_d;
    logic [15:0] settle_q, settle_d;
    logic [7:0]  peak_data_d;
    logic        peak_valid_d;
    logic        stop_pend_q, stop_pend_d;

    logic        vs_edge;
    logic [7:0]  frame_inc;
    logic        win_done;
    logic [7:0]  base;
    logic [7:0]  sampled;
    logic        handshake;

    assign vs_edge   = cmos_vsync & ~vs_q;
    assign frame_inc = frame_q + 8'd1;
    assign win_done  = vs_edge && (frame_inc == WIN_LAST);
    assign handshake = peak_valid & peak_ready;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            vs_q        <= 1'b0;
            run_max_q   <= '0;
            frame_q     <= '0;
            settle_q    <= '0;
            peak_data   <= '0;
            peak_valid  <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= cmos_vsync;
            run_max_q   <= run_max_d;
            frame_q     <= frame_d;
            settle_q    <= settle_d;
            peak_data   <= peak_data_d;
            peak_valid  <= peak_valid_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        run_max_d    = run_max_q;
        frame_d      = frame_q;
        settle_d     = settle_q;
        peak_data_d  = peak_data;
        peak_valid_d = peak_valid;
        stop_pend_d  = stop_pend_q;
        base         = run_max_q;
        sampled      = run_max_q;

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop) begin
                    state_d = WAIT_VS;
                end
            end

            WAIT_VS: begin
                if (stop) begin
                    state_d   = IDLE;
                    run_max_d = '0;
                end else if (vs_edge) begin
                    state_d  = SETTLE;
                    frame_d  = '0;
                    settle_d = '0;
                end
            end

            SETTLE: begin
                if (stop) begin
                    state_d   = IDLE;
                    run_max_d = '0;
                end else if (win_done) begin
                    // A short window can finish before settling completes
                    state_d      = REPORT;
                    frame_d      = frame_inc;
                    peak_data_d  = run_max_q;
                    peak_valid_d = 1'b1;
                end else begin
                    if (vs_edge) begin
                        frame_d = frame_inc;
                    end
                    if (settle_q == SETTLE_LAST) begin
                        state_d = TRACK;
                    end else begin
                        settle_d = settle_q + 16'd1;
                    end
                end
            end

            TRACK: begin
                if (stop) begin
                    state_d   = IDLE;
                    run_max_d = '0;
                end else begin
`ifdef PEAK_DECAY_EN
                    // Decay applies first so a same-cycle sample competes with the decayed peak
                    if (vs_edge && !win_done) begin
                        base = run_max_q - (run_max_q >> 3);
                    end
`endif
                    sampled   = (cmos_frame_href && (indata > base)) ? indata : base;
                    run_max_d = sampled;
                    if (vs_edge) begin
                        frame_d = frame_inc;
                    end
                    if (win_done) begin
                        state_d      = REPORT;
                        peak_data_d  = sampled;
                        peak_valid_d = 1'b1;
                    end
                end
            end

            REPORT: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (handshake) begin
                    peak_valid_d = 1'b0;
                    run_max_d    = '0;
                    frame_d      = '0;
                    settle_d     = '0;
                    if (stop_pend_q || stop) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_peak_window_ctrl.sv
// Directed, table-driven bench for peak_window_ctrl (default build, WIN_FRAMES=4, SETTLE_CYC=25).
module tb_peak_window_ctrl;

    localparam int unsigned SETTLE = 25;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cmos_vsync;
    logic       cmos_frame_href;
    logic [7:0] indata;
    logic [7:0] peak_data;
    logic       peak_valid;
    logic       peak_ready;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    peak_window_ctrl #(
        .WIN_FRAMES(4),
        .SETTLE_CYC(SETTLE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .cmos_vsync     (cmos_vsync),
        .cmos_frame_href(cmos_frame_href),
        .indata         (indata),
        .peak_data      (peak_data),
        .peak_valid     (peak_valid),
        .peak_ready     (peak_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // s[3]/h[3] is the first frame of the window, s[0]/h[0] the last
    typedef struct {
        logic [3:0][7:0] s;
        logic [3:0]      h;
        int              early_idx;
        logic [7:0]      early_val;
        logic [7:0]      first_val;
        logic [7:0]      exp_peak;
    } win_vec_t;

    win_vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        cmos_vsync = 1'b1;
        tick();
        cmos_vsync = 1'b0;
    endtask

    task automatic begin_window();
        start = 1'b1;
        tick();
        start = 1'b0;
        vs_pulse();
    endtask

    // Entered in the first SETTLE cycle; returns in the first REPORT cycle
    task automatic run_window(input win_vec_t v);
        for (int c = 0; c < int'(SETTLE) + 1; c++) begin
            if (c == v.early_idx) begin
                indata          = v.early_val;
                cmos_frame_href = 1'b1;
            end
            tick();
            cmos_frame_href = 1'b0;
            indata          = '0;
        end
        indata          = v.first_val;
        cmos_frame_href = 1'b1;
        tick();
        cmos_frame_href = 1'b0;
        indata          = '0;
        for (int f = 3; f >= 0; f--) begin
            indata          = v.s[f];
            cmos_frame_href = v.h[f];
            tick();
            cmos_frame_href = 1'b0;
            indata          = '0;
            tick();
            vs_pulse();
        end
    endtask

    task automatic report_handshake(input logic [7:0] exp, input int hold);
        for (int k = 0; k < hold; k++) begin
            chk("hold_valid", peak_valid, 1);
            chk("hold_data", peak_data, exp);
            tick();
        end
        peak_ready = 1'b1;
        tick();
        peak_ready = 1'b0;
        chk("ack_valid_clr", peak_valid, 0);
        chk("ack_data_kept", peak_data, exp);
    endtask

    initial begin
        vecs[0] = '{s: {8'd50, 8'd120, 8'd120, 8'd90},  h: 4'b1111, early_idx: -1, early_val: 8'd0,   first_val: 8'd0,   exp_peak: 8'd120};
        vecs[1] = '{s: {8'd255, 8'd20, 8'd30, 8'd5},    h: 4'b0111, early_idx: -1, early_val: 8'd0,   first_val: 8'd0,   exp_peak: 8'd30};
        vecs[2] = '{s: {8'd40, 8'd40, 8'd40, 8'd40},    h: 4'b1111, early_idx: 10, early_val: 8'd200, first_val: 8'd0,   exp_peak: 8'd40};
        vecs[3] = '{s: {8'd100, 8'd150, 8'd199, 8'd0},  h: 4'b1111, early_idx: 25, early_val: 8'd250, first_val: 8'd200, exp_peak: 8'd200};
        vecs[4] = '{s: {8'd7, 8'd7, 8'd7, 8'd7},        h: 4'b1111, early_idx: -1, early_val: 8'd0,   first_val: 8'd0,   exp_peak: 8'd7};
        vecs[5] = '{s: {8'd0, 8'd0, 8'd0, 8'd0},        h: 4'b1111, early_idx: -1, early_val: 8'd0,   first_val: 8'd0,   exp_peak: 8'd0};
        vecs[6] = '{s: {8'd255, 8'd1, 8'd2, 8'd3},      h: 4'b1111, early_idx: -1, early_val: 8'd0,   first_val: 8'd0,   exp_peak: 8'd255};

        rst_n           = 1'b1;
        start           = 1'b0;
        stop            = 1'b0;
        cmos_vsync      = 1'b0;
        cmos_frame_href = 1'b0;
        indata          = '0;
        peak_ready      = 1'b0;
        repeat (3) tick();
        chk("rst_peak_data", peak_data, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wait_vs_busy", busy, 1);
        vs_pulse();

        // Back-to-back windows: each handshake drops straight into the next SETTLE
        for (int i = 0; i < 7; i++) begin
            run_window(vecs[i]);
            chk("report_valid", peak_valid, 1);
            chk("report_data", peak_data, vecs[i].exp_peak);
            chk("report_busy", busy, 1);
            report_handshake(vecs[i].exp_peak, 5);
            chk("resettle_busy", busy, 1);
        end

        // stop in TRACK: immediate IDLE, no report, peak_data retained
        repeat (SETTLE + 1) tick();
        indata          = 8'd180;
        cmos_frame_href = 1'b1;
        tick();
        cmos_frame_href = 1'b0;
        indata          = '0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_track_busy", busy, 0);
        chk("stop_track_valid", peak_valid, 0);
        for (int k = 0; k < 5; k++) begin
            vs_pulse();
            tick();
            chk("idle_no_report", peak_valid, 0);
            chk("idle_data_kept", peak_data, 255);
        end

        // run_max must have been cleared by the stop
        begin_window();
        run_window('{s: {8'd1, 8'd2, 8'd3, 8'd4}, h: 4'b1111, early_idx: -1, early_val: 8'd0, first_val: 8'd0, exp_peak: 8'd4});
        chk("post_stop_data", peak_data, 4);
        chk("post_stop_valid", peak_valid, 1);

        // stop during REPORT: result still delivered, then IDLE
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_rep_valid", peak_valid, 1);
        chk("stop_rep_data", peak_data, 4);
        chk("stop_rep_busy", busy, 1);
        peak_ready = 1'b1;
        tick();
        peak_ready = 1'b0;
        chk("stop_rep_ack_valid", peak_valid, 0);
        chk("stop_rep_idle", busy, 0);
        repeat (3) tick();
        chk("stop_rep_stays_idle", busy, 0);

        // start and stop together in IDLE: stop wins
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", busy, 0);

        // stop in WAIT_VS
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wait_vs_busy2", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_wait_vs", busy, 0);

        // stop in SETTLE
        begin_window();
        repeat (5) tick();
        chk("settle_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_settle", busy, 0);

        // Asynchronous reset during TRACK with run_max=180
        begin_window();
        repeat (SETTLE + 1) tick();
        indata          = 8'd180;
        cmos_frame_href = 1'b1;
        tick();
        cmos_frame_href = 1'b0;
        indata          = '0;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b1;
        #2;
        chk("async_rst_data", peak_data, 0);
        chk("async_rst_valid", peak_valid, 0);
        chk("async_rst_busy", busy, 0);
        tick();
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vs_pulse();
            tick();
            chk("post_rst_no_report", peak_valid, 0);
            chk("post_rst_idle", busy, 0);
        end
        begin_window();
        run_window('{s: {8'd3, 8'd3, 8'd3, 8'd3}, h: 4'b1111, early_idx: -1, early_val: 8'd0, first_val: 8'd0, exp_peak: 8'd3});
        chk("post_rst_report", peak_data, 3);
        report_handshake(8'd3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/peak_window_ctrl.md
PEAK_WINDOW_CTRL -- requirements
Module: peak_window_ctrl

Interface
REQ-001 Parameter WIN_FRAMES, default 4: frames per measurement window, legal range 1-255.
REQ-002 Parameter SETTLE_CYC, default 25: cycles after window start before sampling begins, legal range 0-65535.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin continuous windowed peak measurement.
REQ-006 stop  input  1  one-cycle request to end measurement.
REQ-007 cmos_vsync  input  1  frame sync level; its rising edge marks frame start.
REQ-008 cmos_frame_href  input  1  line-valid qualifier for indata.
REQ-009 indata  input  8  pixel sample, unsigned.
REQ-010 peak_data  output  8  peak of last completed window.
REQ-011 peak_valid  output  1  peak_data valid; held until accepted.
REQ-012 peak_ready  input  1  consumer accepts peak_data when peak_valid and peak_ready are both high.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states IDLE, WAIT_VS, SETTLE, TRACK, REPORT; vsync edge = cmos_vsync high AND previous-cycle registered cmos_vsync low.
REQ-015 IDLE -> WAIT_VS on start=1 and stop=0; start while busy is ignored.
REQ-016 WAIT_VS -> SETTLE on vsync edge; frame counter cleared to 0, settle counter cleared to 0.
REQ-017 SETTLE: settle counter increments each cycle; -> TRACK in the cycle the counter equals SETTLE_CYC (SETTLE_CYC=0: one cycle in SETTLE).
REQ-018 Internal 8-bit run_max updates to indata only in TRACK when cmos_frame_href=1 and indata > run_max (strictly greater); equal or smaller samples are ignored.
REQ-019 Each vsync edge in SETTLE or TRACK increments the 8-bit frame counter; when the increment reaches WIN_FRAMES -> REPORT.
REQ-020 REPORT entry: peak_data <= run_max (including any update in the same cycle), peak_valid <= 1; sampling and frame counting suspended.
REQ-021 REPORT: peak_valid and peak_data stay stable until handshake; on handshake peak_valid <= 0, run_max <= 0, frame counter <= 0, settle counter <= 0, -> SETTLE (or -> IDLE if stop pending).
REQ-022 stop in WAIT_VS, SETTLE or TRACK: -> IDLE next cycle, run_max cleared, no report issued.
REQ-023 stop in REPORT: latched as stop-pending; window result still delivered, then -> IDLE.
REQ-024 stop and start in the same cycle in IDLE: stop wins, remain IDLE.
REQ-025 peak_data retains its last value in IDLE and SETTLE/TRACK; it changes only at REPORT entry.

Reset
REQ-026 rst_n=1 asynchronously forces IDLE, peak_data=0, peak_valid=0, busy=0, run_max=0, all counters 0, stop-pending 0, vsync history 0.
REQ-027 Reset mid-window discards the window; no partial report after reset release.

Configuration
REQ-028 Macro PEAK_DECAY_EN defined: in TRACK, on each vsync edge that does not complete the window, run_max <= run_max - (run_max >> 3), evaluated before any same-cycle sample compare (sample compared against decayed value).
REQ-029 Macro PEAK_DECAY_EN undefined: run_max never decreases within a window; decay logic absent.

Verification
REQ-030 Reset, start, vsync edge, SETTLE_CYC=25 -> sample 200 with href at settle cycle 10 ignored; sample 200 first TRACK cycle accepted.
REQ-031 WIN_FRAMES=4, samples 50,120,120,90 across 4 frames -> REPORT with peak_data=120, peak_valid held for 5 cycles with peak_ready=0, stable, cleared the cycle after peak_ready=1.
REQ-032 indata=255 with href=0 in TRACK -> run_max unchanged; next report does not show 255.
REQ-033 stop in TRACK -> IDLE next cycle, busy=0, peak_valid never asserted; stop during REPORT -> report delivered then IDLE.
REQ-034 rst_n pulsed during TRACK with run_max=180 -> peak_data=0, peak_valid=0, IDLE immediately.
REQ-035 PEAK_DECAY_EN, run_max=160, vsync edge with no samples -> run_max=140; without macro -> 160.
